// File: rtl/globals.sv
// Shared types and constants for the multiply/divide unit and its users.
package globals;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Handshake: start is accepted only when busy=0; done pulses for one cycle as HI/LO take the result.
module muldiv_unit
  import globals::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  muldiv_op_t    op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic          hi_we,
  input  logic          lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic          busy,
  output logic          done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output muldiv_state_t state_dbg
);

  localparam int CW = $clog2(ITERS + 1);

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  muldiv_state_t state, state_next;

  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_a, mag_b, a_orig;
  logic               is_div_q, neg_res, neg_rem, b_zero;

  logic               req_signed, req_div;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign busy       = (state != IDLE);
  assign state_dbg  = state;
  assign req_signed = (op == MULT) || (op == DIV);
  assign req_div    = (op == DIV) || (op == DIVU);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // CALC runs ITERS iterations plus one settle cycle so results land ITERS+2 edges after start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (counter == CW'(ITERS)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc, 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, mag_b};
    div_next  = div_trial[WIDTH] ? div_shift[2*WIDTH-1:0]
                                 : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    prod_fix  = neg_if(acc, neg_res);
    fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo    = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (b_zero) begin
        fix_hi = a_orig;
        fix_lo = '1;
      end else begin
        fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      counter  <= '0;
      acc      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      a_orig   <= '0;
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      b_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wd;
          if (lo_we) lo <= wd;
          if (start) begin
            mag_a    <= abs_w(a, req_signed);
            mag_b    <= abs_w(b, req_signed);
            a_orig   <= a;
            is_div_q <= req_div;
            neg_res  <= req_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= (op == DIV) && a[WIDTH-1];
            b_zero   <= (b == '0);
            counter  <= '0;
            acc      <= {{WIDTH{1'b0}}, req_div ? abs_w(a, req_signed) : abs_w(b, req_signed)};
          end
        end
        CALC: begin
          if (counter != CW'(ITERS)) begin
            acc     <= is_div_q ? div_next : mul_next;
            counter <= counter + 1'b1;
          end
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import globals::*;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  muldiv_op_t    op_i;
  logic [W-1:0]  a_i, b_i, wd;
  logic          hi_we, lo_we;
  logic          busy, done;
  logic [W-1:0]  hi, lo;
  muldiv_state_t state_dbg;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W), .ITERS(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op_i),
    .a(a_i), .b(b_i), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} from ordinary signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int q, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // mode: 0 plain, 1 start+MTHI injected while busy, 2 reset mid-operation, 3 MTHI together with start
  task automatic run_op(input logic [1:0] o, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [63:0] exp, input int mode);
    int dcount, dk;
    logic [63:0] e;
    dcount = 0;
    dk = 0;
    if (mode != 2) exp_q.push_back(exp);
    op_i = muldiv_op_t'(o);
    a_i = ta;
    b_i = tb_v;
    start = 1'b1;
    if (mode == 3) begin
      hi_we = 1'b1;
      wd = 32'h0000_ABCD;
    end
    @(posedge clock); #1;
    start = 1'b0;
    hi_we = 1'b0;
    check("busy_after_start", busy, 1);
    if (mode == 3) check("mthi_with_start", hi, 32'h0000_ABCD);
    for (int k = 1; k <= 40; k++) begin
      if (mode == 1 && k == 10) begin
        start = 1'b1;
        op_i = DIVU;
        a_i = 9;
        b_i = 3;
        hi_we = 1'b1;
        wd = 32'h0000_DEAD;
      end
      if (mode == 2 && k == 15) reset = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      hi_we = 1'b0;
      if (mode == 2 && k == 15) begin
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
      end
      if (done) begin
        dcount++;
        if (dk == 0) dk = k;
        if (mode != 2 && dcount == 1 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("hi", hi, e[63:32]);
          check("lo", lo, e[31:0]);
        end
      end
      if (mode != 2 && k == LAT - 1) check("busy_in_fix", busy, 1);
      if (mode != 2 && k == LAT) check("busy_after_done", busy, 0);
    end
    check("done_count", dcount, (mode == 2) ? 0 : 1);
    if (mode != 2) check("latency", dk, LAT);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    op_i = MULT;
    a_i = '0;
    b_i = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wd = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_state", state_dbg, IDLE);
    reset = 1'b0;

    run_op(2'd0, 32'd7, 32'hFFFF_FFFD, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 3);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 0);
    run_op(2'd3, 32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF}, 0);
    run_op(2'd1, 32'd3, 32'd5, {32'd0, 32'd15}, 1);

    lo_we = 1'b1;
    wd = 32'h0000_1234;
    @(posedge clock); #1;
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_done", done, 0);
    check("mtlo_busy", busy, 0);

    run_op(2'd2, 32'd100, 32'd7, '0, 2);
    run_op(2'd2, 32'd100, 32'd7, {32'd2, 32'd14}, 0);

    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (n % 7 == 3) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, model(ro, ra, rb), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
